muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle processor datapath, replacing the separate fixed-width multiplier and divider with one shared engine. It takes operands from the A/B registers, runs a radix-2 shift-add or restoring-division loop, and delivers a double-width result as HI/LO with a one-cycle completion pulse for the control unit. It supports signed and unsigned modes, abort on exception flush, and a divide-by-zero flag.

## Interface

- WIDTH, 32, operand width in bits (≥ 4); HI and LO are each WIDTH bits.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only when the unit is ready.
- op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- abort  input  1  synchronous cancel of the operation in flight.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in flight (RUN, FIX).
- done  output  1  one-cycle pulse: hi/lo/div_by_zero valid.
- hi  output  WIDTH  MULT: upper product half; DIV: remainder.
- lo  output  WIDTH  MULT: lower product half; DIV: quotient.
- div_by_zero  output  1  set with done when a DIV had b = 0.

## Operation

- States: IDLE, RUN, FIX, DONE. Ready = IDLE or DONE; start accepted only when ready, ignored otherwise (no queuing).
- Accept: latch op, take magnitudes of a and b (signed ops) or raw values (unsigned), record result sign(s), load counter with WIDTH, clear div_by_zero; go to RUN.
- DIV/DIVU with b = 0 at accept: skip to DONE, set div_by_zero; hi/lo keep previous values.
- RUN: one bit per cycle. MULT: shift-add into 2·WIDTH accumulator. DIV: restoring step on WIDTH+1-bit partial remainder. Counter decrements; at 0 go to FIX.
- FIX: signed MULT negates 2·WIDTH product if operand signs differ. Signed DIV: quotient negated if signs differ (truncation toward zero); remainder takes dividend sign. Results written to hi/lo at FIX→DONE edge.
- Signed overflow −2^(WIDTH−1) / −1: lo = 2^(WIDTH−1) bit pattern (most negative), hi = 0; no flag.
- DONE: done = 1 for exactly one cycle, then IDLE unless a new start is accepted (back-to-back allowed).
- abort in RUN or FIX: next state IDLE, no done, hi/lo/div_by_zero unchanged. abort in IDLE/DONE has no effect; abort has priority over start in the same cycle.
- hi/lo hold their value until the next completed, non-divide-by-zero operation.

## Timing

- Reset (reset = 0, any time, asynchronous): state IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, counter = 0; operation in flight discarded.
- start high in cycle 0 (accepted): busy high cycles 1..WIDTH+1, done high in cycle WIDTH+2 (34 for WIDTH=32) with results.
- Divide-by-zero: done and div_by_zero high in cycle 1; busy never asserts.
- Back-to-back: start in the done cycle is accepted; its done appears WIDTH+2 cycles later.
- div_by_zero remains stable after done until the next accepted start.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- WIDTH=32, MULT a=−3 (FFFFFFFD), b=5 -> done at cycle 34, hi=FFFFFFFF, lo=FFFFFFF1; MULTU same operands -> hi=00000004, lo=FFFFFFF1.
- DIV a=−7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0.
- DIV a=10, b=0 with prior hi/lo=1234/5678 -> cycle 1 done=1, div_by_zero=1, hi/lo unchanged, busy stays 0.
- Start MULT, pulse start again at cycle 5 with different operands -> ignored, first result delivered at cycle 34; start in done cycle -> second done at cycle 68.
- abort at cycle 10 of a DIV -> IDLE at cycle 11, no done, hi/lo unchanged; reset driven low at cycle 20 of a MULT -> all outputs 0 immediately, no done after release.
- WIDTH=8 instance: MULT −128 × −128 -> done at cycle 10, hi=40, lo=00; DIV −128 / −1 -> lo=80, hi=00.

Source files
------------

// File: rtl/muldiv_unit.sv
// Shared radix-2 iterative multiply/divide engine: one result bit per cycle,
// double-width result delivered on hi/lo with a one-cycle done pulse.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | ready, waiting for start
    // RUN   | one shift-add / restoring-divide step per cycle
    // FIX   | sign correction, result written to hi/lo on exit
    // DONE  | done pulse, ready for a back-to-back start
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);

    state_t                 state, state_nxt;
    logic                   accept;
    logic [CW-1:0]          count;
    logic [2*WIDTH-1:0]     acc;
    logic [WIDTH-1:0]       operand;
    logic                   is_div, neg_lo, neg_hi;

    logic                   op_signed, b_zero_div;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]     step_nxt, prod_fix;
    logic [WIDTH-1:0]       hi_fix, lo_fix;

    assign op_signed  = ~op[0];
    assign b_zero_div = op[1] && (b == '0);
    assign a_mag      = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (op_signed && b[WIDTH-1]) ? -b : b;

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = b_zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort)                     state_nxt = IDLE;
                else if (count == CW'(1))      state_nxt = FIX;
            end
            FIX:     state_nxt = abort ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, operand};

    always_comb begin
        step_nxt = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_diff[WIDTH]) step_nxt = {acc[2*WIDTH-2:0], 1'b0};
            else                 step_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    assign prod_fix = neg_lo ? -acc : acc;

    always_comb begin
        hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix = prod_fix[WIDTH-1:0];
        if (is_div) begin
            lo_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            acc         <= '0;
            operand     <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            is_div      <= op[1];
            operand     <= op[1] ? b_mag : a_mag;
            acc         <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            count       <= COUNT_LOAD;
            div_by_zero <= b_zero_div;
            neg_lo      <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi      <= op_signed && op[1] && a[WIDTH-1];
        end else if (state == RUN && !abort) begin
            acc   <= step_nxt;
            count <= count - CW'(1);
        end else if (state == FIX && !abort) begin
            hi <= hi_fix;
            lo <= lo_fix;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: a 32-bit instance with randomized and
// directed operations, plus a small 8-bit instance for width-dependent corners.
module tb_muldiv_unit;
    localparam int W = 32;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0, abort8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .abort(abort8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
        .div_by_zero(dz8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0, miscompares = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;
    logic [31:0] m8_hi = '0, m8_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic void ref_model(input int w, input logic [1:0] o,
                                      input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] ph, input logic [31:0] pl,
                                      output logic [31:0] eh, output logic [31:0] el,
                                      output logic dz);
        longint      mask, sx, sy, q, r;
        logic [63:0] p;
        mask = (longint'(1) << w) - 1;
        sx = longint'(x) & mask;
        sy = longint'(y) & mask;
        if (!o[0] && ((sx >> (w - 1)) & 1) != 0) sx = sx - (longint'(1) << w);
        if (!o[0] && ((sy >> (w - 1)) & 1) != 0) sy = sy - (longint'(1) << w);
        dz = 1'b0;
        if (!o[1]) begin
            p  = 64'(sx * sy);
            el = 32'(p & 64'(mask));
            eh = 32'((p >> w) & 64'(mask));
        end else if (sy == 0) begin
            eh = ph;
            el = pl;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            el = 32'(q & mask);
            eh = 32'(r & mask);
        end
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
        exp_t        e;
        logic [31:0] eh, el;
        logic        edz;
        start = 1'b1; op = o; a = x; b = y;
        if (push) begin
            ref_model(W, o, x, y, m_hi, m_lo, eh, el, edz);
            e.hi = eh; e.lo = el; e.dz = edz;
            e.cyc = cyc + 1 + ((o[1] && y == 0) ? 0 : W + 1);
            m_hi = eh; m_lo = el; m_dz = edz;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < W + 8) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no done within %0d cycles", name, k);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name);
        issue(o, x, y, 1'b1);
        if (o[1] && y == 0) begin
            check({name, "_busy1"}, 64'(busy), 64'(0));
            check({name, "_done1"}, 64'(done), 64'(1));
        end else begin
            check({name, "_busy1"}, 64'(busy), 64'(1));
            check({name, "_done1"}, 64'(done), 64'(0));
        end
        wait_done(name);
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, "_idle_done"}, 64'(done), 64'(0));
        check({name, "_idle_busy"}, 64'(busy), 64'(0));
        check({name, "_idle_dz"}, 64'(div_by_zero), 64'(m_dz));
        check({name, "_idle_hi"}, 64'(hi), 64'(m_hi));
        check({name, "_idle_lo"}, 64'(lo), 64'(m_lo));
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input string name);
        logic [31:0] eh, el;
        logic        edz;
        int          k, lat;
        ref_model(8, o, {24'b0, x}, {24'b0, y}, m8_hi, m8_lo, eh, el, edz);
        lat = (o[1] && y == 0) ? 1 : 10;
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(negedge clk);
        k = 1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_cycle"}, 64'(k), 64'(lat));
        check({name, "_hi"}, 64'(hi8), 64'(eh[7:0]));
        check({name, "_lo"}, 64'(lo8), 64'(el[7:0]));
        check({name, "_dz"}, 64'(dz8), 64'(edz));
        m8_hi = {24'b0, eh[7:0]};
        m8_lo = {24'b0, el[7:0]};
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("mon_hi", 64'(hi), 64'(mon_e.hi));
                check("mon_lo", 64'(lo), 64'(mon_e.lo));
                check("mon_dz", 64'(div_by_zero), 64'(mon_e.dz));
                check("mon_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("mon_busy", 64'(busy), 64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [1:0] o;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_dz", 64'(div_by_zero), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        run(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg");
        idle_check("mult_neg");
        check("mult_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
        run(2'b01, 32'hFFFF_FFFD, 32'd5, "multu");
        idle_check("multu");
        check("multu_hi_const", 64'(hi), 64'h4);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run(2'b11, 32'd7, 32'd2, "divu");
        idle_check("divu");
        check("divu_lo_const", 64'(lo), 64'h3);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        idle_check("div_ovf");
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        run(2'b11, 32'h5678_1234, 32'h0001_0000, "divu_prep");
        run(2'b10, 32'd10, 32'd0, "div_zero");
        idle_check("div_zero");
        check("div_zero_hi_const", 64'(hi), 64'h1234);
        check("div_zero_lo_const", 64'(lo), 64'h5678);

        issue(2'b00, 32'd7, 32'hFFFF_FFF7, 1'b1);
        repeat (4) @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("ignored_start");
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done("back_to_back");
        idle_check("back_to_back");

        issue(2'b10, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hi", 64'(hi), 64'(m_hi));
        check("abort_lo", 64'(lo), 64'(m_lo));
        repeat (W + 5) @(negedge clk);

        issue(2'b00, 32'd123, 32'd456, 1'b0);
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'(0));
        check("areset_done", 64'(done), 64'(0));
        check("areset_hi", 64'(hi), 64'(0));
        check("areset_lo", 64'(lo), 64'(0));
        check("areset_dz", 64'(div_by_zero), 64'(0));
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        m8_hi = '0; m8_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (W + 5) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            run(o, rand_val(), rand_val(), "rand");
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end
        idle_check("rand_end");

        run8(2'b00, 8'h80, 8'h80, "w8_mult");
        check("w8_mult_hi_const", 64'(hi8), 64'h40);
        run8(2'b10, 8'h80, 8'hFF, "w8_div_ovf");
        check("w8_div_ovf_lo_const", 64'(lo8), 64'h80);
        run8(2'b11, 8'h55, 8'h00, "w8_divu_zero");
        for (int i = 0; i < 12; i++)
            run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)), "w8_rand");

        k = 0;
        while (sb.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d results never delivered", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
